// File: rtl/apb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_countdown_timer
// Brief    : APB3/APB4 completer with a 32-bit prescaled down-counter,
//            optional auto-reload and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module apb_countdown_timer #(
    parameter int          WAIT_STATES = 1,
    parameter bit          PRIV_ONLY   = 1'b1,
    parameter logic [31:0] ID_VALUE    = 32'h5443_0001
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    input  logic [2:0]  pprot,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        timer_irq
);

    localparam logic [1:0] C_WAIT         = WAIT_STATES[1:0];
    localparam logic [9:0] C_IDX_CTRL     = 10'h000;
    localparam logic [9:0] C_IDX_LOAD     = 10'h001;
    localparam logic [9:0] C_IDX_VALUE    = 10'h002;
    localparam logic [9:0] C_IDX_INTSTAT  = 10'h003;
    localparam logic [9:0] C_IDX_PRESCALE = 10'h004;
    localparam logic [9:0] C_IDX_ID       = 10'h3FF;

    logic [1:0]  r_wait;
    logic [2:0]  r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_value;
    logic        r_intstat;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pcnt;

    logic [9:0]  w_idx;
    logic        w_access;
    logic        w_done;
    logic        w_valid;
    logic        w_ro;
    logic        w_priv_block;
    logic        w_err;
    logic        w_commit;
    logic [31:0] w_rdata;
    logic [31:0] w_load_new;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_intstat;
    logic        w_wr_prescale;
    logic        w_stop;
    logic        w_wrap;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused_bits;

    assign w_unused_bits = ^{paddr[1:0], pprot[2:1]};

    assign w_idx    = paddr[11:2];
    assign w_access = psel & penable;
    assign w_done   = w_access & (r_wait == C_WAIT);

    always_comb begin
        w_valid      = 1'b1;
        w_ro         = 1'b0;
        w_priv_block = 1'b0;
        w_rdata      = 32'h0;
        case (w_idx)
            C_IDX_CTRL: begin
                w_rdata      = {29'h0, r_ctrl};
                w_priv_block = PRIV_ONLY & ~pprot[0];
            end
            C_IDX_LOAD: begin
                w_rdata      = r_load;
                w_priv_block = PRIV_ONLY & ~pprot[0];
            end
            C_IDX_VALUE: begin
                w_rdata = r_value;
                w_ro    = 1'b1;
            end
            C_IDX_INTSTAT:  w_rdata = {31'h0, r_intstat};
            C_IDX_PRESCALE: w_rdata = {24'h0, r_prescale};
            C_IDX_ID: begin
                w_rdata = ID_VALUE;
                w_ro    = 1'b1;
            end
            default:        w_valid = 1'b0;
        endcase
    end

    // Protection only ever rejects writes; reads always succeed on valid offsets.
    assign w_err    = ~w_valid | (pwrite & (w_ro | w_priv_block));
    assign w_commit = w_done & pwrite & ~w_err;

    // Outputs are forced low while reset is held so an abandoned access shows nothing.
    assign pready    = w_done & ~preset;
    assign pslverr   = w_done & w_err & ~preset;
    assign prdata    = (w_done & ~pwrite & ~preset) ? w_rdata : 32'h0;
    assign timer_irq = r_intstat & r_ctrl[1];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_load_new[8*b +: 8] = pstrb[b] ? pwdata[8*b +: 8] : r_load[8*b +: 8];
        end
    end

    assign w_wr_ctrl     = w_commit & (w_idx == C_IDX_CTRL);
    assign w_wr_load     = w_commit & (w_idx == C_IDX_LOAD);
    assign w_wr_intstat  = w_commit & (w_idx == C_IDX_INTSTAT);
    assign w_wr_prescale = w_commit & (w_idx == C_IDX_PRESCALE);

    // A tick is dropped when the same edge disables the timer or reloads LOAD.
    assign w_stop   = w_wr_ctrl & pstrb[0] & ~pwdata[0];
    assign w_wrap   = r_ctrl[0] & (r_pcnt >= r_prescale);
    assign w_tick   = w_wrap & ~w_stop & ~w_wr_load;
    assign w_expire = w_tick & (r_value == 32'd1);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait <= 2'd0;
        end else if (!psel || w_done) begin
            r_wait <= 2'd0;
        end else if (w_access) begin
            r_wait <= r_wait + 2'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_ctrl     <= 3'd0;
            r_prescale <= 8'd0;
        end else begin
            if (w_wr_ctrl && pstrb[0]) begin
                r_ctrl <= pwdata[2:0];
            end
            if (w_wr_prescale && pstrb[0]) begin
                r_prescale <= pwdata[7:0];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pcnt <= 8'd0;
        end else if (!r_ctrl[0] || w_wr_load || w_wrap) begin
            r_pcnt <= 8'd0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_load  <= 32'h0;
            r_value <= 32'h0;
        end else if (w_wr_load) begin
            r_load  <= w_load_new;
            r_value <= w_load_new;
        end else if (w_tick && (r_value != 32'd0)) begin
            if (r_value == 32'd1) begin
                r_value <= r_ctrl[2] ? r_load : 32'h0;
            end else begin
                r_value <= r_value - 32'd1;
            end
        end
    end

    // Expiry has priority over a simultaneous write-one-to-clear.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_intstat <= 1'b0;
        end else if (w_expire) begin
            r_intstat <= 1'b1;
        end else if (w_wr_intstat && pstrb[0] && pwdata[0]) begin
            r_intstat <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_countdown_timer
// Brief    : Directed and randomized APB traffic checked against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_countdown_timer;

    localparam int          WS  = 1;
    localparam logic [31:0] IDV = 32'h5443_0001;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = 12'h0;
    logic [31:0] pwdata = 32'h0;
    logic [3:0]  pstrb = 4'h0;
    logic [2:0]  pprot = 3'h0;
    logic [31:0] prdata;
    logic        pready, pslverr, timer_irq;

    apb_countdown_timer #(.WAIT_STATES(WS), .PRIV_ONLY(1'b1), .ID_VALUE(IDV)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .timer_irq(timer_irq)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: register contents and the prescaler phase
    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_value;
    logic        m_intstat;
    int          m_prescale, m_pcnt;

    function automatic void model_reset();
        m_ctrl = 0; m_load = 0; m_value = 0; m_intstat = 0; m_prescale = 0; m_pcnt = 0;
    endfunction

    function automatic bit model_err(bit wr, logic [11:0] a, logic [2:0] p);
        int idx = int'(a[11:2]);
        if (!(idx inside {0, 1, 2, 3, 4, 1023})) return 1'b1;
        if (wr && (idx == 2 || idx == 1023)) return 1'b1;
        if (wr && (idx == 0 || idx == 1) && !p[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(logic [11:0] a);
        case (int'(a[11:2]))
            0:    return {29'h0, m_ctrl};
            1:    return m_load;
            2:    return m_value;
            3:    return {31'h0, m_intstat};
            4:    return m_prescale;
            1023: return IDV;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_clock(bit wr, logic [11:0] a, logic [31:0] d, logic [3:0] s);
        int idx     = int'(a[11:2]);
        bit load_wr = wr && idx == 1;
        bit stop    = wr && idx == 0 && s[0] && !d[0];
        bit expire  = 0;
        int nxt     = 0;
        if (m_ctrl[0]) begin
            if (m_pcnt >= m_prescale) begin
                if (!load_wr && !stop && m_value != 0) begin
                    if (m_value == 1) begin
                        expire  = 1;
                        m_value = m_ctrl[2] ? m_load : 32'h0;
                    end else m_value = m_value - 1;
                end
            end else nxt = m_pcnt + 1;
        end
        if (wr) begin
            case (idx)
                0: if (s[0]) m_ctrl = d[2:0];
                1: begin
                    for (int b = 0; b < 4; b++) if (s[b]) m_load[8*b +: 8] = d[8*b +: 8];
                    m_value = m_load;
                    nxt = 0;
                end
                3: if (s[0] && d[0]) m_intstat = 0;
                4: if (s[0]) m_prescale = int'(d[7:0]);
                default: ;
            endcase
        end
        if (expire) m_intstat = 1;
        m_pcnt = nxt;
    endfunction

    // Edges until the next expiry given the current model state
    function automatic int edges_to_expiry();
        if (!m_ctrl[0] || m_value == 0) return -1;
        return (m_prescale - m_pcnt + 1) + int'(m_value - 1) * (m_prescale + 1);
    endfunction

    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata, e_rdata;
    bit          e_err;

    // One clock: sample at the falling edge, advance the model at the rising edge
    task automatic step();
        bit comp;
        @(negedge pclk);
        check("irq", {31'h0, timer_irq}, {31'h0, m_ctrl[1] & m_intstat});
        s_pready = pready; s_pslverr = pslverr; s_prdata = prdata;
        e_rdata = model_read(paddr);
        e_err   = model_err(pwrite, paddr, pprot);
        comp    = psel && penable && s_pready;
        @(posedge pclk);
        model_clock(comp && pwrite && !e_err, paddr, pwdata, pstrb);
        #1;
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       output logic [31:0] rd, output logic er);
        int n = 0;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
        step();
        check("setup_rdy", {31'h0, s_pready}, 32'h0);
        penable = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_pready) break;
            n++;
            check("wait_quiet", {s_prdata[30:0], s_pslverr}, 32'h0);
        end
        check("wait_cnt", n, WS);
        rd = s_prdata; er = s_pslverr;
        if (s_pready) begin
            check("pslverr", {31'h0, s_pslverr}, {31'h0, e_err});
            check(wr ? "wr_prdata" : "prdata", s_prdata, (wr || e_err) ? 32'h0 : e_rdata);
        end
        psel = 0; penable = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check("rst_rdata", prdata, 32'h0);
        check("rst_outs", {29'h0, pready, pslverr, timer_irq}, 32'h0);
        preset = 0;

        // ID read with one wait state
        apb(0, 12'hFFC, 0, 0, 3'b001, rd, er);
        check("t1_id", rd, 32'h5443_0001);
        check("t1_err", {31'h0, er}, 32'h0);

        // One-shot countdown from 3
        apb(1, 12'h004, 32'd3, 4'hF, 3'b001, rd, er);
        apb(1, 12'h010, 32'd0, 4'hF, 3'b001, rd, er);
        apb(1, 12'h000, 32'd3, 4'hF, 3'b001, rd, er);
        apb(0, 12'h008, 0, 0, 3'b001, rd, er);
        idle(6);
        check("t2_irq", {31'h0, timer_irq}, 32'h1);
        apb(0, 12'h00C, 0, 0, 3'b001, rd, er);
        check("t2_intstat", rd, 32'h1);
        apb(0, 12'h008, 0, 0, 3'b001, rd, er);
        check("t2_value", rd, 32'h0);

        // Auto-reload, then W1C colliding with expiry
        apb(1, 12'h000, 32'd0, 4'hF, 3'b001, rd, er);
        apb(1, 12'h00C, 32'd1, 4'hF, 3'b001, rd, er);
        apb(1, 12'h004, 32'd2, 4'hF, 3'b001, rd, er);
        apb(1, 12'h010, 32'd1, 4'hF, 3'b001, rd, er);
        apb(1, 12'h000, 32'd7, 4'hF, 3'b001, rd, er);
        begin
            int cnt = 0;
            while (!timer_irq && cnt < 20) begin step(); cnt++; end
            check("t3_latency", cnt, 4);
            check("t3_value", m_value, 32'd2);
            apb(0, 12'h008, 0, 0, 3'b001, rd, er);
            cnt = 0;
            while (edges_to_expiry() != 2 + WS && cnt < 20) begin step(); cnt++; end
            check("t3_align", edges_to_expiry(), 2 + WS);
            apb(1, 12'h00C, 32'd1, 4'h1, 3'b001, rd, er);
            check("t3_set_wins", {31'h0, m_intstat}, 32'h1);
            apb(0, 12'h00C, 0, 0, 3'b001, rd, er);
            check("t3_intstat", rd, 32'h1);
        end

        // Protection and unmapped offsets
        apb(1, 12'h000, 32'd0, 4'hF, 3'b000, rd, er);
        check("t4_prot_err", {31'h0, er}, 32'h1);
        apb(0, 12'h000, 0, 0, 3'b000, rd, er);
        check("t4_ctrl_kept", rd, 32'h7);
        apb(1, 12'h020, 32'h55, 4'hF, 3'b001, rd, er);
        check("t4_unmapped_wr", {31'h0, er}, 32'h1);
        apb(0, 12'h020, 0, 0, 3'b001, rd, er);
        check("t4_unmapped_rd", {rd[30:0], er}, 32'h1);

        // Byte strobes on LOAD
        apb(1, 12'h000, 32'd0, 4'hF, 3'b001, rd, er);
        apb(1, 12'h004, 32'd0, 4'hF, 3'b001, rd, er);
        apb(1, 12'h004, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er);
        apb(0, 12'h004, 0, 0, 3'b001, rd, er);
        check("t5_strobe", rd, 32'h00BB00DD);

        // Reset in the middle of a LOAD write's completing cycle
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h004; pwdata = 32'h1234; pstrb = 4'hF; pprot = 3'b001;
        step();
        penable = 1;
        step();
        preset = 1;
        #1;
        check("t6_outs", {pready, pslverr, timer_irq, prdata[28:0]}, 32'h0);
        model_reset();
        psel = 0; penable = 0;
        @(posedge pclk); #1;
        preset = 0;
        apb(0, 12'h004, 0, 0, 3'b001, rd, er);
        check("t6_load", rd, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 250; k++) begin
            logic [11:0] a;
            logic [31:0] d;
            bit          wr;
            case ($urandom_range(0, 7))
                0: a = 12'h000;
                1: a = 12'h004;
                2: a = 12'h008;
                3: a = 12'h00C;
                4: a = 12'h010;
                5: a = 12'hFFC;
                6: a = 12'($urandom);
                default: a = 12'($urandom_range(0, 4) * 4);
            endcase
            a[1:0] = 2'($urandom);
            wr = ($urandom_range(0, 2) != 0);
            d  = $urandom;
            if (a[11:2] == 10'h001 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 12);
            if (a[11:2] == 10'h004 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 3);
            apb(wr, a, d, 4'($urandom), 3'($urandom), rd, er);
            idle($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
